// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin two-client push/pop sequencer for a shared LIFO stack
module stack_arbiter #(
   parameter int B = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         op0,
   input  logic [B-1:0] wdata0,
   output logic         ack0,
   output logic [B-1:0] rdata0,
   output logic         err0,
   input  logic         req1,
   input  logic         op1,
   input  logic [B-1:0] wdata1,
   output logic         ack1,
   output logic [B-1:0] rdata1,
   output logic         err1,
   output logic         stk_push,
   output logic         stk_pop,
   output logic [B-1:0] stk_w_data,
   input  logic [B-1:0] stk_r_data,
   input  logic         stk_full,
   input  logic         stk_empty,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
   state_t       state_q;
   logic         gnt_q, op_q, last_q;
   logic [B-1:0] wdata_q;
   logic         ack0_q, ack1_q, err0_q, err1_q;
   logic [B-1:0] rdata0_q, rdata1_q;
   logic         gnt_d, err_d;
   logic [B-1:0] rd_d;
   // grant winner, error flag and captured pop data for the operation in flight
   always_comb begin
      gnt_d = (req0 & req1) ? ~last_q : req1;
      err_d = op_q ? stk_full : stk_empty;
      rd_d  = (~op_q & ~stk_empty) ? stk_r_data : '0;
   end
   // IDLE -> ISSUE -> ACK sequencer; ack/rdata/err are registered and live only in ACK
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         op_q     <= 1'b0;
         last_q   <= 1'b1;
         wdata_q  <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         case (state_q)
            IDLE: if (req0 | req1) begin
               gnt_q   <= gnt_d;
               last_q  <= gnt_d;
               op_q    <= gnt_d ? op1 : op0;
               wdata_q <= gnt_d ? wdata1 : wdata0;
               state_q <= ISSUE;
            end
            ISSUE: begin
               ack0_q   <= ~gnt_q;
               ack1_q   <= gnt_q;
               err0_q   <= ~gnt_q & err_d;
               err1_q   <= gnt_q & err_d;
               rdata0_q <= gnt_q ? '0 : rd_d;
               rdata1_q <= gnt_q ? rd_d : '0;
               state_q  <= ACK;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign stk_push   = (state_q == ISSUE) & op_q & ~stk_full;
   assign stk_pop    = (state_q == ISSUE) & ~op_q & ~stk_empty;
   assign stk_w_data = (state_q == ISSUE) ? wdata_q : '0;
   assign busy       = state_q != IDLE;
   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign err0       = err0_q;
   assign err1       = err1_q;
   assign rdata0     = rdata0_q;
   assign rdata1     = rdata1_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed scoreboard bench for stack_arbiter against a 16-deep stack model
module tb_stack_arbiter;
   logic       clk = 1'b0, reset = 1'b1;
   logic       req0 = 0, op0 = 0, req1 = 0, op1 = 0;
   logic [7:0] wdata0 = 0, wdata1 = 0;
   logic       ack0, err0, ack1, err1, stk_push, stk_pop, stk_full, stk_empty, busy;
   logic [7:0] rdata0, rdata1, stk_w_data, stk_r_data;
   int total = 0, bad = 0;

   typedef struct packed {logic c; logic [7:0] d; logic e;} exp_t;
   exp_t       sbq[$];
   logic [7:0] sh[$];

   logic [7:0] mem [16];
   logic [4:0] sp = 5'd0;

   stack_arbiter #(.B(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_w_data(stk_w_data),
      .stk_r_data(stk_r_data), .stk_full(stk_full), .stk_empty(stk_empty), .busy(busy)
   );

   always #5 clk = ~clk;

   assign stk_full  = sp == 5'd16;
   assign stk_empty = sp == 5'd0;
   assign stk_r_data = stk_empty ? 8'h00 : mem[4'(sp - 5'd1)];

   always @(posedge clk) begin
      if (stk_push && !stk_full) begin
         mem[sp[3:0]] <= stk_w_data;
         sp <= sp + 5'd1;
      end else if (stk_pop && !stk_empty) sp <= sp - 5'd1;
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   always @(negedge clk) begin
      chk("strobe_excl", {31'd0, stk_push & stk_pop}, 0);
      chk("strobe_idle", {31'd0, (stk_push | stk_pop) & ~busy}, 0);
      if (ack0 | ack1) begin
         chk("ack_excl", {31'd0, ack0 & ack1}, 0);
         if (sbq.size() == 0) chk("unexp_ack", {30'd0, ack1, ack0}, 0);
         else begin
            exp_t x;
            x = sbq.pop_front();
            chk("ack_client", {31'd0, ack1}, {31'd0, x.c});
            chk("rdata", {24'd0, x.c ? rdata1 : rdata0}, {24'd0, x.d});
            chk("err", {31'd0, x.c ? err1 : err0}, {31'd0, x.e});
            chk("other_quiet", {23'd0, x.c ? {rdata0, err0} : {rdata1, err1}}, 0);
         end
      end
   end

   function automatic exp_t expect_op(input logic c, input logic op, input logic [7:0] d);
      exp_t x;
      x.c = c;
      x.d = 8'h00;
      if (op) begin
         x.e = sh.size() == 16;
         if (!x.e) sh.push_back(d);
      end else begin
         x.e = sh.size() == 0;
         if (!x.e) x.d = sh.pop_back();
      end
      return x;
   endfunction

   task automatic do_op(input logic c, input logic op, input logic [7:0] d);
      exp_t x;
      x = expect_op(c, op, d);
      sbq.push_back(x);
      if (c) begin req1 = 1; op1 = op; wdata1 = d; end
      else begin req0 = 1; op0 = op; wdata0 = d; end
      @(negedge clk);
      chk("busy_issue", {31'd0, busy}, 1);
      chk("push_strobe", {31'd0, stk_push}, {31'd0, op & ~x.e});
      chk("pop_strobe", {31'd0, stk_pop}, {31'd0, ~op & ~x.e});
      chk("w_data", {24'd0, stk_w_data}, {24'd0, d});
      @(negedge clk);
      chk("ack_latency", {31'd0, c ? ack1 : ack0}, 1);
      req0 = 0;
      req1 = 0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int gap, last_ack;
      repeat (2) @(negedge clk);
      chk("rst_outs", {15'd0, ack0, ack1, err0, err1, stk_push, stk_pop, busy, rdata0, rdata1}, 0);
      chk("rst_wdata", {24'd0, stk_w_data}, 0);
      reset = 0;
      @(negedge clk);
      // contention from reset: grants 0,1,0,1... three cycles apart
      for (int k = 0; k < 8; k++) sbq.push_back(expect_op(k[0], 1'b1, k[0] ? 8'h22 : 8'h11));
      req0 = 1; op0 = 1; wdata0 = 8'h11;
      req1 = 1; op1 = 1; wdata1 = 8'h22;
      last_ack = 0;
      for (int k = 0; k < 8; k++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (!(ack0 | ack1) && gap < 10);
         chk("contend_ack", {31'd0, ack0 | ack1}, 1);
         if (k > 0) chk("ack_gap", gap, 3);
         last_ack = gap;
      end
      req0 = 0;
      req1 = 0;
      @(negedge clk);
      for (int k = 0; k < 8; k++) do_op(k[0], 1'b0, 8'h00);
      // error pop on empty, then push/pop basics
      do_op(1'b0, 1'b0, 8'h00);
      do_op(1'b0, 1'b1, 8'hA5);
      do_op(1'b1, 1'b1, 8'h3C);
      do_op(1'b1, 1'b0, 8'h00);
      do_op(1'b0, 1'b0, 8'h00);
      // reset during ISSUE drops strobe and ack
      req0 = 1; op0 = 1; wdata0 = 8'h5A;
      @(negedge clk);
      chk("rst_issue_push", {31'd0, stk_push}, 1);
      #2 reset = 1;
      #1;
      chk("rst_mid_strobe", {30'd0, stk_push, busy}, 0);
      req0 = 0;
      @(negedge clk);
      reset = 0;
      repeat (4) @(negedge clk);
      chk("rst_lost_op", {27'd0, sp}, 0);
      do_op(1'b1, 1'b1, 8'h77);
      do_op(1'b0, 1'b0, 8'h00);
      // fill 16, overflow, drain in reverse, underflow
      for (int k = 0; k < 16; k++) do_op(k[0], 1'b1, 8'(8'hC0 + k));
      do_op(1'b0, 1'b1, 8'hEE);
      for (int k = 0; k < 16; k++) do_op(k[0], 1'b0, 8'h00);
      do_op(1'b1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
